// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and default widths for the instruction-memory arbiter.
// Revision 1.0
`default_nettype none

package imem_arb_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int ADDR_WIDTH_DEF     = 10;
  localparam int MAX_LOAD_BURST_DEF = 4;
  localparam int CNT_WIDTH_DEF      = 32;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } t_arb_state;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_LOAD  = 2'd2
  } t_grant;

  // Bits needed to hold a starvation count in the range 0..max_burst.
  function automatic int starve_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_arb_perf.sv
// imem_arb_perf: fetch-grant and fetch-stall event counters, wrapping on overflow.
// Revision 1.0
`default_nettype none

module imem_arb_perf
  import imem_arb_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 fetch_gnt,
  input  logic                 fetch_req_valid,
  output logic [CNT_WIDTH-1:0] fetch_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_gnt) begin
        fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
      end
      if (fetch_req_valid && !fetch_gnt) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port instruction memory between fetch (read) and loader (write).
// Optional counters via macro IMEM_ARB_PERF_EN. Revision 1.0
`default_nettype none

module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int MAX_LOAD_BURST = MAX_LOAD_BURST_DEF
`ifdef IMEM_ARB_PERF_EN
  ,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_load_mode,
  input  logic                  i_fetch_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                  o_fetch_req_ready,
  output logic                  o_fetch_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_fetch_rsp_data,
  input  logic                  i_fetch_rsp_ready,
  input  logic                  i_load_valid,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_load_ready,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  o_load_active
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_perf_fetch_cnt,
  output logic [CNT_WIDTH-1:0]  o_perf_stall_cnt
`endif
);

  localparam int SW = starve_width(MAX_LOAD_BURST);

  t_arb_state            state;
  t_arb_state            state_nxt;
  t_grant                grant;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [SW-1:0]         starve_cnt;
  logic                  fslot;
  logic                  burst_left;
  logic                  fetch_gnt;
  logic                  load_gnt;

  assign fslot      = !rsp_valid || i_fetch_rsp_ready;
  assign burst_left = (starve_cnt < SW'(MAX_LOAD_BURST));

  // Grants are suppressed while reset is asserted so no write leaks out asynchronously.
  always_comb begin
    grant = GNT_NONE;
    if (!i_arst) begin
      unique case (state)
        S_RUN: begin
          if (i_load_valid && (!i_fetch_req_valid || burst_left || !fslot)) begin
            grant = GNT_LOAD;
          end else if (i_fetch_req_valid && fslot) begin
            grant = GNT_FETCH;
          end
        end
        S_LOAD: begin
          if (i_load_valid) begin
            grant = GNT_LOAD;
          end
        end
        default: grant = GNT_NONE;
      endcase
    end
  end

  assign fetch_gnt = (grant == GNT_FETCH);
  assign load_gnt  = (grant == GNT_LOAD);

  assign o_fetch_req_ready = fetch_gnt;
  assign o_load_ready      = load_gnt;
  assign o_mem_write_en    = load_gnt;
  assign o_mem_addr        = load_gnt ? i_load_addr : i_fetch_addr;
  assign o_mem_write_data  = i_load_data;
  assign o_fetch_rsp_valid = rsp_valid;
  assign o_fetch_rsp_data  = rsp_data;
  assign o_load_active     = (state == S_LOAD);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN: begin
        if (i_load_mode) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fslot) begin
          state_nxt = i_load_mode ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (!i_load_mode) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state     <= S_RUN;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_gnt) begin
        rsp_valid <= 1'b1;
        rsp_data  <= i_mem_read_data;
      end else if (i_fetch_rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Starvation only accrues while fetch is both waiting and able to take a response.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      starve_cnt <= '0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (fetch_gnt || !i_fetch_req_valid) begin
            starve_cnt <= '0;
          end else if (load_gnt && fslot && burst_left) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        S_DRAIN: begin
          if (!i_fetch_req_valid || (state_nxt == S_LOAD)) begin
            starve_cnt <= '0;
          end
        end
        default: starve_cnt <= '0;
      endcase
    end
  end

`ifdef IMEM_ARB_PERF_EN
  imem_arb_perf #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf (
    .clk             (i_clk),
    .arst            (i_arst),
    .fetch_gnt       (fetch_gnt),
    .fetch_req_valid (i_fetch_req_valid),
    .fetch_cnt       (o_perf_fetch_cnt),
    .stall_cnt       (o_perf_stall_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port instruction memory between two requesters: the core fetch unit (read-only) and the program loader/debug writer (write-only).
- Per-cycle arbitration with a bounded-starvation policy.
- Registered fetch response with a valid/ready handshake.
- A load-mode FSM gives the loader exclusive ownership after draining any in-flight fetch response.
- Sits between the fetch stage/loader and the instruction memory; later reused in front of the I-cache fill port.

Parameters:
DATA_WIDTH, 32, instruction/data word width
ADDR_WIDTH, 10, word address width into memory
MAX_LOAD_BURST, 4, max consecutive loader grants while fetch waits (must be >=1)
CNT_WIDTH, 32, width of performance counters (optional feature only)

Ports:
i_clk  in  1  clock
i_arst  in  1  asynchronous active-high reset
i_load_mode  in  1  request exclusive loader ownership
i_fetch_req_valid  in  1  fetch request valid
i_fetch_addr  in  ADDR_WIDTH  fetch word address
o_fetch_req_ready  out  1  fetch request accepted (granted) this cycle
o_fetch_rsp_valid  out  1  fetch response valid
o_fetch_rsp_data  out  DATA_WIDTH  fetched instruction
i_fetch_rsp_ready  in  1  fetch unit accepts response
i_load_valid  in  1  loader write valid
i_load_addr  in  ADDR_WIDTH  loader write address
i_load_data  in  DATA_WIDTH  loader write data
o_load_ready  out  1  loader write performed this cycle
o_mem_write_en  out  1  memory write enable
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_write_data  out  DATA_WIDTH  memory write data
i_mem_read_data  in  DATA_WIDTH  memory combinational read data
o_load_active  out  1  high in S_LOAD

Behaviour:
- Reset (async, i_arst=1) sets the following; all other outputs are combinational from these plus inputs:
  - state=S_RUN, rsp_valid=0, rsp_data=0, starve_cnt=0.
- Memory-side grant rules:
  - Memory performs a combinational read.
  - Fetch grant: o_mem_addr=i_fetch_addr, o_mem_write_en=0. i_mem_read_data is captured into the rsp register at the clock edge. Latency: handshake in cycle N -> o_fetch_rsp_valid in N+1.
  - Loader grant: o_mem_write_en=1, o_mem_addr=i_load_addr, o_mem_write_data=i_load_data. o_load_ready=1 in the same cycle.
  - No grant: o_mem_addr=i_fetch_addr, write_en=0.
- Fetch slot free: fslot = !rsp_valid || i_fetch_rsp_ready. Back-to-back fetch with bypass is allowed: 1 instr/cycle when the consumer is always ready.
- Response register:
  - rsp_valid clears on i_fetch_rsp_ready unless a new grant occurs in the same cycle; then it stays 1 with new data.
  - rsp_data holds stable while valid && !ready.
- S_RUN arbitration, per cycle:
  - Loader only -> loader granted.
  - Fetch only and fslot -> fetch granted.
  - Both valid:
    - Loader wins if starve_cnt < MAX_LOAD_BURST or !fslot.
    - Otherwise fetch wins.
  - starve_cnt increments on a loader grant while i_fetch_req_valid && fslot, saturating at MAX_LOAD_BURST. It clears on a fetch grant or whenever i_fetch_req_valid=0.
- FSM:
  - S_RUN -> S_DRAIN when i_load_mode=1.
  - S_DRAIN:
    - No fetch and no loader grants.
    - Leaves when rsp_valid=0, or is being accepted this cycle: to S_LOAD if i_load_mode=1, else to S_RUN.
  - S_LOAD:
    - Only loader grants; o_fetch_req_ready=0; o_load_active=1.
    - -> S_RUN when i_load_mode=0, effective the next cycle; a loader write in the exit cycle is still performed.
  - S_DRAIN with i_load_mode dropping early: returns to S_RUN after the drain (no S_LOAD).
- starve_cnt is cleared on entry to S_LOAD.
- Reset mid-operation discards the pending response; no memory write occurs during reset.

Optional Feature:
Macro IMEM_ARB_PERF_EN.
- When defined, adds outputs o_perf_fetch_cnt and o_perf_stall_cnt (CNT_WIDTH each, reset 0, wrap on overflow).
  - o_perf_fetch_cnt: number of fetch grants.
  - o_perf_stall_cnt: cycles with i_fetch_req_valid=1 and no fetch grant.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package imem_arb_pkg:
  - typedef enum logic [1:0] t_arb_state {S_RUN, S_DRAIN, S_LOAD}.
  - typedef enum t_grant {GNT_NONE, GNT_FETCH, GNT_LOAD}.
  - Constants for default widths.
- One sub-module, imem_arb_perf (the counters), instantiated only under IMEM_ARB_PERF_EN.

Test Plan:
1. Fetch only, rsp_ready=1, addresses 0..7 on consecutive cycles -> 8 responses in cycles 1..8, data = mem[0..7], req_ready constantly 1.
2. rsp_ready=0 after first response (addr 3) -> req_ready=0, rsp_data holds mem[3], no new memory reads granted. rsp_ready=1 -> next fetch granted in the same cycle.
3. Loader and fetch both continuously valid, MAX_LOAD_BURST=4 -> grant pattern L,L,L,L,F repeating. starve_cnt clears after each F.
4. Write 0xDEADBEEF to addr 5 via loader, then fetch addr 5 -> response 0xDEADBEEF one cycle after fetch grant.
5. i_load_mode=1 with rsp_valid=1 and rsp_ready=0 for 3 cycles -> stays in S_DRAIN, no grants. rsp_ready=1 -> S_LOAD next cycle, o_load_active=1, fetch blocked. i_load_mode=0 -> S_RUN.
6. Assert i_arst mid-burst with rsp_valid=1 -> rsp_valid=0, state S_RUN, o_mem_write_en=0 immediately (asynchronous).
